icache_fill: RTL and testbench

Direct-mapped, read-only instruction cache with a line-fill state machine, placed between the PC register and the 4-cycle main memory. It replaces the ideal single-cycle instruction memory: hits return the instruction in the same cycle, and misses stall the CPU while the line fills. The CPU consumes `inst` and `stall`. The unified memory arbiter consumes the `mem_*` request port.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_fill_if.sv | 24 ++
 rtl/icache_array.sv | 55 +++++
 rtl/icache_fill.sv | 141 ++++++++++++++
 tb/tb_icache_fill.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_fill shared types, default geometry and derived-width helpers.
// Optional feature macro: ICACHE_PERF_CNT_EN (miss counter port).
package icache_pkg;

  typedef enum logic {
    IC_IDLE,
    IC_FILL
  } ic_state_t;

  localparam int SETS_DEF = 64;
  localparam int WPL_DEF  = 8;

  function automatic int ob_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int ib_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int wpl);
    return 15 - $clog2(wpl) - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_fill_if.sv
// Instruction-cache line-fill read port toward the memory arbiter.
// One word per request; responses return in request order.
interface icache_fill_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_rvalid
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache.
// Async read; one tag port (sets valid), one word port, one invalidate.
module icache_array
  import icache_pkg::*;
#(
  parameter int SETS = SETS_DEF,
  parameter int WPL  = WPL_DEF,
  parameter int TW   = tag_w(SETS_DEF, WPL_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ib_w(SETS)-1:0]  rd_idx,
  input  logic [ob_w(WPL)-1:0]   rd_off,
  output logic                   rd_valid,
  output logic [TW-1:0]          rd_tag,
  output logic [15:0]            rd_data,
  input  logic [ib_w(SETS)-1:0]  wr_idx,
  input  logic                   inv_en,
  input  logic                   tag_we,
  input  logic [TW-1:0]          tag_wdata,
  input  logic                   word_we,
  input  logic [ob_w(WPL)-1:0]   word_off,
  input  logic [15:0]            word_wdata
);

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [15:0]     data [SETS][WPL];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_off];

  // valid: set on tag write, cleared when a fill starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[wr_idx] <= 1'b1;
    end else if (inv_en) begin
      valid[wr_idx] <= 1'b0;
    end
  end

  // tag and data arrays carry no reset
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tags[wr_idx] <= tag_wdata;
    end
    if (word_we) begin
      data[wr_idx][word_off] <= word_wdata;
    end
  end

endmodule

// File: rtl/icache_fill.sv
// Direct-mapped read-only icache with IDLE/FILL line-fill FSM.
// `ICACHE_PERF_CNT_EN adds a saturating miss_cnt output.
module icache_fill
  import icache_pkg::*;
#(
  parameter int SETS = SETS_DEF,
  parameter int WPL  = WPL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        fetch_en,
  output logic [15:0] inst,
  output logic        stall,
  output logic        fill_busy,
`ifdef ICACHE_PERF_CNT_EN
  output logic [15:0] miss_cnt,
`endif
  icache_fill_if.master mem
);

  localparam int OB = ob_w(WPL);
  localparam int IB = ib_w(SETS);
  localparam int TW = tag_w(SETS, WPL);
  localparam int HW = 15 - OB;

  localparam logic [OB:0]   NWORD = (OB+1)'(WPL);
  localparam logic [OB:0]   R_ONE = (OB+1)'(1);
  localparam logic [OB-1:0] LASTW = OB'(WPL - 1);
  localparam logic [OB-1:0] C_ONE = OB'(1);

  logic [OB-1:0] off;
  logic [IB-1:0] idx;
  logic [TW-1:0] tag;
  logic          unused_pc0;

  assign off        = pc[OB:1];
  assign idx        = pc[OB+IB:OB+1];
  assign tag        = pc[15:OB+IB+1];
  assign unused_pc0 = pc[0];

  ic_state_t     state;
  logic [OB:0]   req_cnt;
  logic [OB-1:0] rcv_cnt;
  logic [HW-1:0] line_hi;

  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [15:0]   rd_data;
  logic [IB-1:0] wr_idx;
  logic          idle;
  logic          fill;
  logic          hit;
  logic          miss;
  logic          word_we;
  logic          last;

  assign idle = (state == IC_IDLE);
  assign fill = (state == IC_FILL);
  assign hit  = idle & fetch_en & rd_valid & (rd_tag == tag);
  assign miss = idle & fetch_en & ~hit;

  assign inst      = hit ? rd_data : 16'h0000;
  assign stall     = miss | ~idle;
  assign fill_busy = fill;

  assign mem.mem_req  = fill & (req_cnt < NWORD);
  assign mem.mem_addr = mem.mem_req
                      ? {line_hi, req_cnt[OB-1:0], 1'b0}
                      : 16'h0000;

  assign word_we = fill & mem.mem_rvalid;
  assign last    = word_we & (rcv_cnt == LASTW);
  assign wr_idx  = fill ? line_hi[IB-1:0] : idx;

  icache_array #(
    .SETS (SETS),
    .WPL  (WPL),
    .TW   (TW)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (idx),
    .rd_off     (off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_idx     (wr_idx),
    .inv_en     (miss),
    .tag_we     (last),
    .tag_wdata  (line_hi[HW-1:IB]),
    .word_we    (word_we),
    .word_off   (rcv_cnt),
    .word_wdata (mem.mem_rdata)
  );

  // fill FSM: latch line on miss, stream requests, count responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IC_IDLE;
      req_cnt <= '0;
      rcv_cnt <= '0;
      line_hi <= '0;
    end else begin
      unique case (state)
        IC_IDLE: begin
          if (miss) begin
            state   <= IC_FILL;
            line_hi <= pc[15:OB+1];
            req_cnt <= '0;
            rcv_cnt <= '0;
          end
        end
        IC_FILL: begin
          if (mem.mem_req) begin
            req_cnt <= req_cnt + R_ONE;
          end
          if (mem.mem_rvalid) begin
            rcv_cnt <= rcv_cnt + C_ONE;
            if (rcv_cnt == LASTW) begin
              state <= IC_IDLE;
            end
          end
        end
        default: state <= IC_IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // saturating count of IDLE->FILL transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= 16'h0000;
    end else if (miss && miss_cnt != 16'hFFFF) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill with an in-order memory model.
// Build with +define+ICACHE_PERF_CNT_EN to cover miss_cnt.
module tb_icache_fill;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        fetch_en;
  logic [15:0] inst;
  logic        stall;
  logic        fill_busy;
`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] miss_cnt;
`endif

  icache_fill_if m ();

  icache_fill dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .fetch_en  (fetch_en),
    .inst      (inst),
    .stall     (stall),
    .fill_busy (fill_busy),
`ifdef ICACHE_PERF_CNT_EN
    .miss_cnt  (miss_cnt),
`endif
    .mem       (m)
  );

  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  int cyc;
  int last_rv;
  int next_ok;
  bit gaps;
  bit stale;

  typedef struct {
    logic [15:0] a;
    int          due;
  } rq_t;

  rq_t q[$];

  always @(posedge clk) cyc++;

  // in-order memory: fixed latency, optional random gaps
  always @(negedge clk) begin : mem_model
    rq_t r;
    m.mem_rvalid = 1'b0;
    m.mem_rdata  = 16'h0000;
    if (q.size() > 0 && q[0].due <= cyc && cyc >= next_ok) begin
      r = q.pop_front();
      m.mem_rvalid = 1'b1;
      m.mem_rdata  = stale ? 16'hDEAD : (r.a ^ 16'hA5A5);
      last_rv = cyc;
      next_ok = cyc + 1 + (gaps ? int'($urandom_range(0, 3)) : 0);
    end
    if (m.mem_req) q.push_back('{m.mem_addr, cyc + LAT});
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    fetch_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_line(input logic [15:0] base);
    for (int w = 0; w < 8; w++) begin
      pc = base + 16'(2 * w);
      #1;
      chk("line_word", inst, pc ^ 16'hA5A5);
    end
  endtask

  // miss at cycle 0, then follow until stall drops
  task automatic do_fill(input logic [15:0] p, input bit strict);
    logic [15:0] base;
    int n;
    int nreq;
    bit bad;
    base = p & 16'hFFF0;
    n = 0;
    nreq = 0;
    bad = 1'b0;
    @(posedge clk); #1;
    pc = p;
    fetch_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (!stall) break;
      if (!strict && k == 3) begin
        pc = p ^ 16'h5550;
        fetch_en = 1'b0;
      end
      if (!strict && k == 5) begin
        pc = p;
        fetch_en = 1'b1;
      end
      if (m.mem_req) begin
        if (m.mem_addr !== base + 16'(2 * nreq) || k != nreq + 1)
          bad = 1'b1;
        nreq++;
      end
      n++;
    end
    if (strict) chk("fill_cycles", n, 13);
    else chk("stall_drop", cyc, last_rv + 1);
    chk("req_count", nreq, 8);
    chk("req_addr", bad, 0);
    chk("fill_inst", inst, {p[15:1], 1'b0} ^ 16'hA5A5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit quiet_bad;
    clk = 1'b0;
    rst_n = 1'b1;
    fetch_en = 1'b0;
    pc = 16'h0000;
    m.mem_rvalid = 1'b0;
    m.mem_rdata = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_req", m.mem_req, 0);
    chk("rst_addr", m.mem_addr, 16'h0000);
    chk("rst_busy", fill_busy, 0);
    fetch_en = 1'b1;
    #1 chk("rst_stall_fe", stall, 1);
    fetch_en = 1'b0;
    rst_n = 1'b1;

    // cold miss
    do_fill(16'h0000, 1'b1);
    chk_line(16'h0000);

    // hits after fill
    pc = 16'h0006;
    #1;
    chk("hit6_inst", inst, 16'hA5A3);
    chk("hit6_stall", stall, 0);
    chk("hit6_req", m.mem_req, 0);
    pc = 16'h000E;
    #1 chk("hitE_inst", inst, 16'hA5AB);
    fetch_en = 1'b0;
    #1;
    chk("fe0_inst", inst, 16'h0000);
    chk("fe0_stall", stall, 0);
    fetch_en = 1'b1;

    // conflict miss then re-miss on original line
    do_fill(16'h0400, 1'b1);
    do_fill(16'h0000, 1'b1);

    // irregular returns, pc wiggled mid-fill
    gaps = 1'b1;
    do_fill(16'h1234, 1'b0);
    chk_line(16'h1230);
    gaps = 1'b0;

    // reset during cycle 6 of a fill
    @(posedge clk); #1;
    pc = 16'h2000;
    fetch_en = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    stale = 1'b1;
    #1;
    chk("mid_rst_busy", fill_busy, 0);
    chk("mid_rst_req", m.mem_req, 0);
    chk("mid_rst_stall", stall, 1);
    fetch_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet_bad = 1'b0;
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      @(negedge clk); #1;
      if (stall || m.mem_req || fill_busy) quiet_bad = 1'b1;
    end
    chk("stale_quiet", quiet_bad, 0);
    chk("stale_drain", q.size(), 0);
    @(posedge clk); #1;
    stale = 1'b0;
    fetch_en = 1'b1;
    pc = 16'h2000;
    #1 chk("post_rst_miss", stall, 1);
    fetch_en = 1'b0;
    do_fill(16'h2000, 1'b1);
    chk_line(16'h2000);

`ifdef ICACHE_PERF_CNT_EN
    do_reset();
    #1 chk("perf_rst", miss_cnt, 16'd0);
    do_fill(16'h0000, 1'b1);
    do_fill(16'h0010, 1'b1);
    do_fill(16'h0020, 1'b1);
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      pc = 16'(h * 16);
      if (h > 2) pc = 16'h0022;
      @(negedge clk);
      chk("perf_hit", stall, 0);
    end
    chk("perf_cnt", miss_cnt, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
